// File: rtl/ledpanel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ledpanel_pkg
// Description : Shared constants, state encoding and helpers for the LED
//               panel framebuffer datapath (RGB565 pixels, 64x64 panels).
// Contents    : PIXEL_W, PANEL_ADDR_W, BITS_RED/GREEN/BLUE, state_t and
//               the ST_* state constants, ptr_width() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ledpanel_pkg;

    localparam int PIXEL_W      = 16;
    localparam int PANEL_ADDR_W = 12;

    localparam int BITS_RED     = 5;
    localparam int BITS_GREEN   = 6;
    localparam int BITS_BLUE    = 5;

    // Write-arbiter state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_GRANT     = 2'd1;
    localparam state_t ST_SWAP_WAIT = 2'd2;

    // Width of a pointer that indexes n requesters; never narrower than 1.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ledpanel_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ledpanel_rr_pick
// Description : Combinational round-robin picker. Selects the first set bit
//               of valid at or after index ptr, wrapping at NUM_REQ.
// Ports       : valid [NUM_REQ] request vector
//               ptr   [PTR_W]   starting index (must be < NUM_REQ)
//               grant [NUM_REQ] one-hot selection (all zero if none valid)
//               idx   [PTR_W]   index of the selected bit
//               any             at least one bit of valid is set
// Revision    : 1.0 - initial release
// ============================================================================
module ledpanel_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    // Offset k walks outward from ptr; the first valid hit wins. The modulo
    // keeps the wrap at NUM_REQ rather than at the next power of two.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && valid[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = PTR_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ledpanel_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ledpanel_fb_arbiter
// Description : Owns the framebuffer write port. Round-robin arbitration
//               with burst locking between NUM_REQ writers; writes land in
//               the back bank; page flips are committed only on vblank.
// Ports       : ctrl_clk, ctrl_rst          clock, sync active-high reset
//               req_valid/ready/last        per-requester handshake
//               req_addr/req_wdat           packed per-requester beat data
//               swap_req, vblank            flip request / frame-end pulse
//               mem_we/mem_addr/mem_wdat    framebuffer write port
//               disp_bank, swap_done, busy  status
// Revision    : 1.0 - initial release
// ============================================================================
module ledpanel_fb_arbiter
    import ledpanel_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = PANEL_ADDR_W,
    parameter int DATA_BITS = PIXEL_W,
    parameter int BURST_MAX = 64
) (
    input  logic                           ctrl_clk,
    input  logic                           ctrl_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdat,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic                           swap_req,
    input  logic                           vblank,
    output logic                           mem_we,
    output logic [ADDR_BITS:0]             mem_addr,
    output logic [DATA_BITS-1:0]           mem_wdat,
    output logic                           disp_bank,
    output logic                           swap_done,
    output logic                           busy
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic                 swap_pending;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 flip_q;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdat;
    logic                 sel_last;
    logic                 accept;
    logic                 release_burst;
    logic                 vblank_flip;

    ledpanel_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Slice of the granted requester; gnt_oh is one-hot so a plain OR-mux.
    always_comb begin
        sel_addr = '0;
        sel_wdat = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_wdat = req_wdat[i*DATA_BITS +: DATA_BITS];
                sel_last = req_last[i];
            end
        end
    end

    // A pending flip closes the grant at once so no beat reaches the bank
    // that is about to become visible.
    assign req_ready     = (state == ST_GRANT && !swap_pending) ? gnt_oh : '0;
    assign accept        = |(req_valid & req_ready);
    assign release_burst = accept && (sel_last || beat_cnt == CNT_LAST);
    assign vblank_flip   = (state == ST_SWAP_WAIT) && vblank;
    assign busy          = (state == ST_GRANT) || (state == ST_SWAP_WAIT);

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            gnt_idx      <= '0;
            gnt_oh       <= '0;
            swap_pending <= 1'b0;
            beat_cnt     <= '0;
            flip_q       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdat     <= '0;
            disp_bank    <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            // Write path: the back bank is the complement of the bank on
            // display at the acceptance cycle.
            mem_we <= accept;
            if (accept) begin
                mem_addr <= {~disp_bank, sel_addr};
                mem_wdat <= sel_wdat;
            end

            // swap_done trails the disp_bank change by one cycle.
            flip_q    <= vblank_flip;
            swap_done <= flip_q;
            if (vblank_flip) begin
                disp_bank <= ~disp_bank;
            end

            // Clearing on the flip wins over a coincident request, and a
            // request while already pending is absorbed.
            if (vblank_flip) begin
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (swap_pending) begin
                        state <= ST_SWAP_WAIT;
                    end else if (pick_any) begin
                        gnt_idx <= pick_idx;
                        gnt_oh  <= pick_oh;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_burst) begin
                        rr_ptr   <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
                        beat_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end else if (swap_pending) begin
                        // Truncated burst: rr_ptr is left alone so the
                        // interrupted writer is first in line after the flip.
                        beat_cnt <= '0;
                        state    <= ST_SWAP_WAIT;
                    end
                end
                ST_SWAP_WAIT: begin
                    if (vblank) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ledpanel_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ledpanel_fb_arbiter
// Description : Self-checking bench for ledpanel_fb_arbiter. A behavioural
//               model tracks grants, flips and expected framebuffer writes;
//               expected writes go into a scoreboard queue that a separate
//               monitor drains whenever mem_we is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ledpanel_fb_arbiter;

    localparam int NR = 3;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int BM = 64;

    logic               clk;
    logic               ctrl_rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdat;
    logic [NR-1:0]      req_last;
    logic               swap_req;
    logic               vblank;
    logic               mem_we;
    logic [AW:0]        mem_addr;
    logic [DW-1:0]      mem_wdat;
    logic               disp_bank;
    logic               swap_done;
    logic               busy;

    ledpanel_fb_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .BURST_MAX (BM)
    ) dut (
        .ctrl_clk  (clk),
        .ctrl_rst  (ctrl_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdat  (req_wdat),
        .req_last  (req_last),
        .swap_req  (swap_req),
        .vblank    (vblank),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdat  (mem_wdat),
        .disp_bank (disp_bank),
        .swap_done (swap_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            last;
    } beat_t;

    typedef struct {
        logic [AW:0]   addr;
        logic [DW-1:0] dat;
        int            cyc;
    } wr_t;

    beat_t bq [NR][$];
    wr_t   wq [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_total [NR];
    bit armed    = 1'b0;
    bit stall_en = 1'b0;

    // Reference model: phase 0 = waiting, 1 = granted, 2 = waiting for vblank.
    int m_phase, m_own, m_ptr, m_cnt;
    bit m_pend, m_bank, m_d1, m_d2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_burst(input int r, input int base, input int len,
                              input bit rand_data, input logic [DW-1:0] d, input bit with_last);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.a    = AW'(base + k);
            b.d    = rand_data ? DW'($urandom) : d;
            b.last = with_last && (k == len - 1);
            bq[r].push_back(b);
        end
    endtask

    // Apply one cycle of stimulus, check outputs against the model, then
    // advance the model by the rules of the arbiter.
    task automatic step(input bit sw, input bit vb, input bit rs);
        logic [NR-1:0] exp_ready;
        bit            acc, flip, found;
        int            j;
        @(negedge clk);
        ctrl_rst = rs;
        swap_req = sw;
        vblank   = vb;
        for (int i = 0; i < NR; i++) begin
            if (bq[i].size() > 0 && !(stall_en && $urandom_range(0, 4) == 0)) begin
                req_valid[i]          = 1'b1;
                req_addr[i*AW +: AW]  = bq[i][0].a;
                req_wdat[i*DW +: DW]  = bq[i][0].d;
                req_last[i]           = bq[i][0].last;
            end else begin
                req_valid[i]          = 1'b0;
                req_addr[i*AW +: AW]  = AW'($urandom);
                req_wdat[i*DW +: DW]  = DW'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
        #1;
        exp_ready = (m_phase == 1 && !m_pend) ? (NR'(1) << m_own) : '0;
        if (armed) begin
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("disp_bank", 64'(disp_bank), 64'(m_bank));
            chk("swap_done", 64'(swap_done), 64'(m_d2));
        end
        if (rs) begin
            m_phase = 0; m_ptr = 0; m_cnt = 0; m_own = 0;
            m_pend = 0; m_bank = 0; m_d1 = 0; m_d2 = 0;
            armed = 1'b1;
        end else begin
            flip = 1'b0;
            acc  = exp_ready[m_own] && req_valid[m_own];
            if (acc) begin
                wq.push_back('{addr: {~m_bank, req_addr[m_own*AW +: AW]},
                               dat: req_wdat[m_own*DW +: DW], cyc: cyc});
            end
            case (m_phase)
                0: begin
                    if (m_pend) begin
                        m_phase = 2;
                    end else begin
                        found = 1'b0;
                        for (int k = 0; k < NR; k++) begin
                            j = (m_ptr + k) % NR;
                            if (!found && req_valid[j]) begin
                                found = 1'b1;
                                m_own = j;
                            end
                        end
                        if (found) m_phase = 1;
                    end
                end
                1: begin
                    if (acc) begin
                        if (req_last[m_own] || m_cnt == BM - 1) begin
                            m_ptr   = (m_own + 1) % NR;
                            m_cnt   = 0;
                            m_phase = 0;
                        end else begin
                            m_cnt++;
                        end
                    end else if (m_pend) begin
                        m_cnt   = 0;
                        m_phase = 2;
                    end
                end
                default: begin
                    if (vb) begin
                        m_bank  = ~m_bank;
                        flip    = 1'b1;
                        m_phase = 0;
                    end
                end
            endcase
            m_d2 = m_d1;
            m_d1 = flip;
            if (flip) m_pend = 1'b0;
            else if (sw) m_pend = 1'b1;
        end
        // Requesters advance on the handshake they see.
        for (int i = 0; i < NR; i++) begin
            if (!rs && req_valid[i] && req_ready[i]) begin
                void'(bq[i].pop_front());
                acc_total[i]++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NR; i++) if (bq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Run until every requester has emptied its queue; vblank pulses keep
    // any pending flip from stalling the drain.
    task automatic drain(input int limit);
        int n = 0;
        while (!queues_empty() && n < limit) begin
            step(1'b0, (n % 16) == 15, 1'b0);
            n++;
        end
        if (!queues_empty()) begin
            failures++;
            $display("FAIL drain timeout at cycle %0d: %0d cycles without emptying queues", cyc, limit);
        end
        idle(3);
    endtask

    task automatic wait_acc(input int r, input int target, input int limit);
        int n = 0;
        while (acc_total[r] < target && n < limit) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (acc_total[r] < target) begin
            failures++;
            $display("FAIL accept timeout req%0d: accepted %0d, needed %0d", r, acc_total[r], target);
        end
    endtask

    // Monitor: every observed write must match the oldest expected one and
    // arrive exactly one cycle after acceptance; otherwise the port holds.
    initial begin
        logic [AW:0]   hold_addr;
        logic [DW-1:0] hold_dat;
        bit            rst_edge;
        wr_t           e;
        hold_addr = '0;
        hold_dat  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = ctrl_rst;
            #1;
            if (armed) begin
                if (rst_edge) begin
                    hold_addr = '0;
                    hold_dat  = '0;
                end
                if (mem_we) begin
                    if (wq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected write at cycle %0d: addr %h data %h, expected none", cyc, mem_addr, mem_wdat);
                    end else begin
                        e = wq.pop_front();
                        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                        chk("mem_wdat", 64'(mem_wdat), 64'(e.dat));
                        chk("write latency", 64'(cyc), 64'(e.cyc + 1));
                        hold_addr = e.addr;
                        hold_dat  = e.dat;
                    end
                end else begin
                    chk("mem_addr hold", 64'(mem_addr), 64'(hold_addr));
                    chk("mem_wdat hold", 64'(mem_wdat), 64'(hold_dat));
                end
            end
        end
    end

    initial begin
        ctrl_rst  = 1'b1;
        swap_req  = 1'b0;
        vblank    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdat  = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) acc_total[i] = 0;

        // Reset then idle.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(4);

        // Single writer, three beats of red.
        push_burst(0, 0, 3, 1'b0, 16'hF800, 1'b1);
        drain(50);

        // Fairness: two writers with 2-beat bursts.
        for (int k = 0; k < 4; k++) begin
            push_burst(0, 16 + 2*k, 2, 1'b1, '0, 1'b1);
            push_burst(1, 64 + 2*k, 2, 1'b1, '0, 1'b1);
        end
        drain(100);

        // 70-beat burst is cut at 64 and the grant passes on.
        push_burst(0, 128, 70, 1'b1, '0, 1'b1);
        push_burst(1, 512, 2, 1'b1, '0, 1'b1);
        drain(300);

        // Swap mid-burst, vblank ten cycles later.
        push_burst(0, 1024, 12, 1'b1, '0, 1'b1);
        wait_acc(0, acc_total[0] + 4, 50);
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        drain(100);

        // swap_req and vblank together in idle, then a duplicate request.
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 1'b0);
        idle(4);

        // Reset in GRANT with a pending flip; first grant after goes to req0.
        push_burst(0, 2000, 1, 1'b1, '0, 1'b1);
        drain(50);
        push_burst(1, 2100, 20, 1'b1, '0, 1'b1);
        wait_acc(1, acc_total[1] + 3, 50);
        push_burst(0, 2200, 2, 1'b1, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        drain(200);

        // Randomized traffic with stalls, flips, vblanks and rare resets.
        stall_en = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                int r = $urandom_range(0, NR - 1);
                if (bq[r].size() < 16) begin
                    if ($urandom_range(0, 49) == 0)
                        push_burst(r, $urandom, $urandom_range(65, 70), 1'b1, '0, 1'b1);
                    else
                        push_burst(r, $urandom, $urandom_range(1, 8), 1'b1, '0, 1'b1);
                end
            end
            step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 699) == 0);
        end
        stall_en = 1'b0;
        drain(2000);

        idle(3);
        chk("scoreboard empty", 64'(wq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
